// File: rtl/mem_port_arbiter.sv
// Shares one single-port sram between the fetch port and the data port: one transaction at a time.
// Optional feature macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              stall
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    // The grant cycle is the first sram cycle of a read, so READ lasts RD_LAT-1 cycles.
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 2);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_src_d;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_tie_d;
    logic w_d_win;
    logic w_if_win;
    logic w_rd_start;
    logic w_rd_src_d;
    logic w_capture;
    logic w_cap_d;

`ifdef MEM_ARB_RR_EN
    // Last winner: 1 = data port. Reset to data so the fetch port wins the first tie.
    logic r_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b1;
        end else if (if_gnt || d_gnt) begin
            r_last_d <= d_gnt;
        end
    end

    assign w_tie_d = ~r_last_d;
`else
    assign w_tie_d = 1'b1;
`endif

    assign w_d_win  = d_req & (~if_req | w_tie_d);
    assign w_if_win = if_req & ~w_d_win;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        mem_cs       = 1'b1;
        mem_oe       = 1'b1;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        w_rd_start   = 1'b0;
        w_rd_src_d   = 1'b0;
        w_capture    = 1'b0;
        w_cap_d      = r_src_d;
        case (r_state)
            S_IDLE: begin
                if (w_d_win) begin
                    d_gnt    = 1'b1;
                    mem_cs   = 1'b0;
                    mem_addr = d_addr;
                    if (d_we) begin
                        mem_we  = 1'b1;
                        mem_din = d_wdata;
                    end else begin
                        mem_oe     = 1'b0;
                        w_rd_start = 1'b1;
                        w_rd_src_d = 1'b1;
                    end
                end else if (w_if_win) begin
                    if_gnt     = 1'b1;
                    mem_cs     = 1'b0;
                    mem_oe     = 1'b0;
                    mem_addr   = if_addr;
                    w_rd_start = 1'b1;
                    w_rd_src_d = 1'b0;
                end
                if (w_rd_start) begin
                    // Single-cycle sram: data is captured at the end of the grant cycle.
                    if (RD_LAT == 1) begin
                        w_capture = 1'b1;
                        w_cap_d   = w_rd_src_d;
                    end else begin
                        w_state_next = S_READ;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            S_READ: begin
                mem_cs   = 1'b0;
                mem_oe   = 1'b0;
                mem_addr = r_addr;
                if (r_cnt == 2'd0) begin
                    w_capture    = 1'b1;
                    w_cap_d      = r_src_d;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_addr      <= '0;
            r_src_d     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            if (w_rd_start) begin
                r_addr  <= mem_addr;
                r_src_d <= w_rd_src_d;
            end
            r_if_rvalid <= w_capture & ~w_cap_d;
            r_d_rvalid  <= w_capture & w_cap_d;
            if (w_capture && !w_cap_d) begin
                r_if_rdata <= mem_dout;
            end
            if (w_capture && w_cap_d) begin
                r_d_rdata <= mem_dout;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall     = (if_req & ~if_gnt) | (d_req & ~d_gnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3), directed cases then random traffic,
// every cycle compared against a transaction-level model. Honors MEM_ARB_RR_EN like the design.
module tb_mem_port_arbiter;

    localparam int N = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [N];
    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        if_gnt    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [31:0] d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic        d_gnt     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic        mem_cs    [N];
    logic        mem_oe    [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_din   [N];
    logic [31:0] mem_dout  [N];
    logic        stall     [N];
    logic [31:0] garbage   [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            mem_port_arbiter #(
                .ADDR_W(32),
                .DATA_W(32),
                .RD_LAT((gi == 0) ? 1 : 3)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n[gi]),
                .if_req   (if_req[gi]),
                .if_addr  (if_addr[gi]),
                .if_gnt   (if_gnt[gi]),
                .if_rvalid(if_rvalid[gi]),
                .if_rdata (if_rdata[gi]),
                .d_req    (d_req[gi]),
                .d_we     (d_we[gi]),
                .d_addr   (d_addr[gi]),
                .d_wdata  (d_wdata[gi]),
                .d_gnt    (d_gnt[gi]),
                .d_rvalid (d_rvalid[gi]),
                .d_rdata  (d_rdata[gi]),
                .mem_cs   (mem_cs[gi]),
                .mem_oe   (mem_oe[gi]),
                .mem_we   (mem_we[gi]),
                .mem_addr (mem_addr[gi]),
                .mem_din  (mem_din[gi]),
                .mem_dout (mem_dout[gi]),
                .stall    (stall[gi])
            );
        end
    endgenerate

    // Sram contents are a fixed function of the address; unselected cycles return noise.
    function automatic logic [31:0] sram_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C22_0004;
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_dout[i] = (!mem_cs[i] && !mem_oe[i]) ? sram_word(mem_addr[i]) : garbage[i];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: memory busy counter plus one pending read (due cycle, value, destination port).
    int          busy     [N];
    logic [31:0] busy_addr[N];
    bit          pend     [N];
    int          due      [N];
    bit          pend_d   [N];
    logic [31:0] pend_val [N];
    logic [31:0] exp_ird  [N];
    logic [31:0] exp_drd  [N];
    bit          last_d   [N];
    bit          m_ig     [N];
    bit          m_dg     [N];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", name, i, cyc, act, exp);
        end
    endtask

    task automatic start_read(input int i, input logic [31:0] a, input bit to_d);
        pend[i]      = 1'b1;
        due[i]       = cyc + lat_of(i);
        pend_val[i]  = sram_word(a);
        pend_d[i]    = to_d;
        busy[i]      = lat_of(i) - 1;
        busy_addr[i] = a;
    endtask

    task automatic model_check();
        for (int i = 0; i < N; i++) begin
            logic        e_ig, e_dg, e_irv, e_drv, e_cs, e_oe, e_we, e_stall;
            logic [31:0] e_addr, e_din;
            bit          d_wins;
            e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0;
            e_cs = 1; e_oe = 1; e_we = 0; e_addr = 0; e_din = 0;
            if (!rst_n[i]) begin
                busy[i] = 0; pend[i] = 0; exp_ird[i] = 0; exp_drd[i] = 0; last_d[i] = 1;
            end else begin
                if (pend[i] && due[i] == cyc) begin
                    pend[i] = 0;
                    if (pend_d[i]) begin e_drv = 1; exp_drd[i] = pend_val[i]; end
                    else begin e_irv = 1; exp_ird[i] = pend_val[i]; end
                end
                if (busy[i] > 0) begin
                    e_cs = 0; e_oe = 0; e_addr = busy_addr[i];
                    busy[i]--;
                end else if (if_req[i] || d_req[i]) begin
                    if (if_req[i] && d_req[i]) d_wins = RR ? !last_d[i] : 1'b1;
                    else d_wins = d_req[i];
                    last_d[i] = d_wins;
                    e_cs = 0;
                    if (d_wins) begin
                        e_dg = 1; e_addr = d_addr[i];
                        if (d_we[i]) begin e_we = 1; e_din = d_wdata[i]; end
                        else begin e_oe = 0; start_read(i, d_addr[i], 1'b1); end
                    end else begin
                        e_ig = 1; e_oe = 0; e_addr = if_addr[i];
                        start_read(i, if_addr[i], 1'b0);
                    end
                end
            end
            e_stall = (if_req[i] & ~e_ig) | (d_req[i] & ~e_dg);
            chk("if_gnt", i, if_gnt[i], e_ig);
            chk("d_gnt", i, d_gnt[i], e_dg);
            chk("if_rvalid", i, if_rvalid[i], e_irv);
            chk("d_rvalid", i, d_rvalid[i], e_drv);
            chk("if_rdata", i, if_rdata[i], exp_ird[i]);
            chk("d_rdata", i, d_rdata[i], exp_drd[i]);
            chk("mem_cs", i, mem_cs[i], e_cs);
            chk("mem_oe", i, mem_oe[i], e_oe);
            chk("mem_we", i, mem_we[i], e_we);
            chk("mem_addr", i, mem_addr[i], e_addr);
            chk("mem_din", i, mem_din[i], e_din);
            chk("stall", i, stall[i], e_stall);
            m_ig[i] = e_ig;
            m_dg[i] = e_dg;
        end
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) garbage[i] = $urandom;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 32'h10;
            1: return 32'h40;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit sg_i [4];
        bit sg_d [4];
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 0; if_req[i] = 0; if_addr[i] = 0; d_req[i] = 0; d_we[i] = 0;
            d_addr[i] = 0; d_wdata[i] = 0; garbage[i] = $urandom;
            busy[i] = 0; pend[i] = 0; exp_ird[i] = 0; exp_drd[i] = 0; last_d[i] = 1;
        end
        tick();
        settle();
        chk("rst_if_rdata", 0, if_rdata[0], 32'h0);
        chk("rst_mem_cs", 0, mem_cs[0], 1'b1);
        chk("rst_d_rvalid", 1, d_rvalid[1], 1'b0);
        advance();
        for (int i = 0; i < N; i++) rst_n[i] = 1;
        tick();

        // Fetch 0x10 on the RD_LAT=1 instance.
        if_req[0] = 1; if_addr[0] = 32'h10;
        settle(); chk("fetch_gnt", 0, if_gnt[0], 1'b1); advance();
        if_req[0] = 0;
        settle();
        chk("fetch_rvalid", 0, if_rvalid[0], 1'b1);
        chk("fetch_rdata", 0, if_rdata[0], 32'h8C22_0004);
        advance();
        tick();

        // Load 0x40 on the RD_LAT=3 instance.
        d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h40;
        settle(); chk("load_gnt", 1, d_gnt[1], 1'b1); chk("load_oe_t0", 1, mem_oe[1], 1'b0); advance();
        d_req[1] = 0;
        settle(); chk("load_oe_t1", 1, mem_oe[1], 1'b0); advance();
        settle(); chk("load_oe_t2", 1, mem_oe[1], 1'b0); chk("load_rv_t2", 1, d_rvalid[1], 1'b0); advance();
        settle();
        chk("load_rvalid", 1, d_rvalid[1], 1'b1);
        chk("load_rdata", 1, d_rdata[1], 32'hDEAD_BEEF);
        chk("load_if_rdata", 1, if_rdata[1], 32'h0);
        advance();

        // Store with a concurrent fetch on the RD_LAT=1 instance.
        d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h80; d_wdata[0] = 32'h1234_5678;
        if_req[0] = 1; if_addr[0] = 32'h20;
        settle();
        chk("st_d_gnt", 0, d_gnt[0], 1'b1);
        chk("st_if_gnt", 0, if_gnt[0], 1'b0);
        chk("st_mem_we", 0, mem_we[0], 1'b1);
        chk("st_mem_din", 0, mem_din[0], 32'h1234_5678);
        chk("st_stall", 0, stall[0], 1'b1);
        advance();
        d_req[0] = 0; d_we[0] = 0;
        settle(); chk("st_if_gnt_t1", 0, if_gnt[0], 1'b1); chk("st_stall_t1", 0, stall[0], 1'b0); advance();
        if_req[0] = 0;
        tick();

        // Both ports held for four grants after a fresh reset.
        rst_n[0] = 0; tick(); rst_n[0] = 1; tick();
        if_req[0] = 1; if_addr[0] = 32'h100; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            settle(); sg_i[k] = if_gnt[0]; sg_d[k] = d_gnt[0]; advance();
        end
        if_req[0] = 0; d_req[0] = 0;
        for (int k = 0; k < 4; k++) begin
            chk("tie_order", 0, {30'd0, sg_i[k], sg_d[k]},
                (RR && (k % 2 == 0)) ? 32'd2 : 32'd1);
        end
        tick();

        // Reset in the second cycle of a RD_LAT=3 read.
        if_req[1] = 1; if_addr[1] = 32'h10;
        settle(); chk("abort_gnt", 1, if_gnt[1], 1'b1); advance();
        if_req[1] = 0; rst_n[1] = 0;
        tick();
        rst_n[1] = 1;
        for (int k = 0; k < 4; k++) begin
            settle(); chk("abort_no_rvalid", 1, if_rvalid[1], 1'b0); advance();
        end
        if_req[1] = 1;
        settle(); chk("refetch_gnt", 1, if_gnt[1], 1'b1); advance();
        if_req[1] = 0;
        tick(); tick();
        settle(); chk("refetch_rvalid", 1, if_rvalid[1], 1'b1); chk("refetch_rdata", 1, if_rdata[1], 32'h8C22_0004);
        advance();

        // Random traffic with occasional drops and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rst_n[i]) rst_n[i] = 1;
                else if ($urandom_range(0, 399) == 0) rst_n[i] = 0;
                if (if_req[i] && !m_ig[i]) begin
                    if ($urandom_range(0, 19) == 0) if_req[i] = 0;
                end else begin
                    if_req[i]  = ($urandom_range(0, 99) < 45);
                    if_addr[i] = rand_addr();
                end
                if (d_req[i] && !m_dg[i]) begin
                    if ($urandom_range(0, 19) == 0) d_req[i] = 0;
                end else begin
                    d_req[i]   = ($urandom_range(0, 99) < 45);
                    d_we[i]    = $urandom_range(0, 1) == 1;
                    d_addr[i]  = rand_addr();
                    d_wdata[i] = $urandom;
                end
                if (!rst_n[i]) begin if_req[i] = 0; d_req[i] = 0; end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
